// File: rtl/timer_device.sv
// ---------------------------------------------------------------------------
// timer_device
//   Memory-mapped countdown timer on the CPU data bus. It has a 16-byte
//   register window at BASE_ADDR and raises one interrupt line for CP0.
//   It supports one-shot and auto-reload modes.
//
//   Register map (offset = addr[3:2]):
//     0 CTRL   [0]=EN, [2:1]=MODE (01 = auto-reload, otherwise one-shot),
//              [3]=IM (interrupt mask). Bits [31:4] read as 0.
//     1 PRESET 32-bit reload value. A value of 0 counts like 1.
//     2 COUNT  read-only current count.
//     3 reserved: reads 0, writes are ignored.
//
//   Bus handshake: there is no valid/ready pair. An access is always
//   accepted in the cycle it is presented. Any set bit in byteen makes the
//   access a write, and the selected byte lanes commit at the next posedge.
//   rdata is a combinational function of addr and the current registers.
//
// Ports
//   clk     in   system clock; all state changes on posedge
//   reset   in   asynchronous, active-low reset
//   addr    in   32-bit byte address
//   byteen  in   4-bit byte write enables
//   wdata   in   32-bit store data (lanes aligned to addr[1:0]=0)
//   rdata   out  32-bit read data (combinational)
//   irq     out  interrupt request (registered flag & IM)
//   state_o out  debug view of the FSM state (0 IDLE,1 LOAD,2 CNT,3 INT)
// ---------------------------------------------------------------------------
module timer_device #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7f00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  ctrl_q,   ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q,  count_d;
  logic        flag_q,   flag_d;

  logic        sel;
  logic [1:0]  off;
  logic        wr;
  logic        wr_ctrl;
  logic        wr_preset;
  logic        en;
  logic        auto_reload;
  logic        unused_addr_lsbs;

  assign sel         = (addr[31:4] == BASE_ADDR[31:4]);
  assign off         = addr[3:2];
  assign wr          = sel & (|byteen);
  assign wr_ctrl     = wr & (off == 2'd0);
  assign wr_preset   = wr & (off == 2'd1);
  assign en          = ctrl_q[0];
  assign auto_reload = (ctrl_q[2:1] == 2'b01);
  // The register window is word-addressed, so the byte offset bits are unused.
  assign unused_addr_lsbs = ^addr[1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      ctrl_q   <= 4'd0;
      preset_q <= 32'd0;
      count_q  <= 32'd0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    flag_d   = flag_q;

    // A write to CTRL or PRESET acknowledges the interrupt. Expiry in the
    // same cycle overrides this below, so an expiry event is never lost.
    if (wr_ctrl || wr_preset) begin
      flag_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (en) state_d = S_LOAD;
      end
      S_LOAD: begin
        // The FSM samples PRESET only here. A write during CNT takes
        // effect on the next reload.
        count_d = preset_q;
        state_d = S_CNT;
      end
      S_CNT: begin
        if (!en) begin
          state_d = S_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          // A count of 0 (PRESET=0) expires on the same edge as a count
          // of 1, so the count never wraps.
          count_d = 32'd0;
          flag_d  = 1'b1;
          state_d = S_INT;
        end
      end
      S_INT: begin
        if (auto_reload) begin
          flag_d  = 1'b0;
          state_d = S_LOAD;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = S_IDLE;
        end
      end
    endcase

    // A bus write to CTRL comes after the hardware EN clear, so the bus value wins.
    if (wr_ctrl && byteen[0]) begin
      ctrl_d = wdata[3:0];
    end
    if (wr_preset) begin
      for (int b = 0; b < 4; b++) begin
        if (byteen[b]) preset_d[8*b +: 8] = wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    rdata = 32'd0;
    if (sel) begin
      case (off)
        2'd0:    rdata = {28'd0, ctrl_q};
        2'd1:    rdata = preset_q;
        2'd2:    rdata = count_q;
        default: rdata = 32'd0;
      endcase
    end
  end

  assign irq     = flag_q & ctrl_q[3];
  assign state_o = state_q;

endmodule

// File: tb/tb_timer_device.sv
module tb_timer_device;

  localparam logic [31:0] BASE     = 32'h0000_7f00;
  localparam logic [31:0] A_CTRL   = BASE + 32'h0;
  localparam logic [31:0] A_PRESET = BASE + 32'h4;
  localparam logic [31:0] A_COUNT  = BASE + 32'h8;
  localparam logic [31:0] A_RSVD   = BASE + 32'hc;
  localparam logic [31:0] A_OTHER  = 32'h0000_8f00;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;
  logic [1:0]  state_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  timer_device #(.BASE_ADDR(BASE)) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .byteen (byteen),
    .wdata  (wdata),
    .rdata  (rdata),
    .irq    (irq),
    .state_o(state_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    addr = a; byteen = be; wdata = d;
    @(posedge clk);
    #1;
    byteen = 4'd0; wdata = 32'd0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr = a; byteen = 4'd0;
    #1;
    d = rdata;
  endtask

  task automatic do_reset();
    reset = 1'b0; addr = 32'd0; byteen = 4'd0; wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // ---------------- reference model ----------------
  // The model follows the timer's documented rules: it arms, reloads,
  // counts down and then expires or reloads.
  localparam int M_IDLE = 0, M_LOAD = 1, M_CNT = 2, M_INT = 3;
  bit          m_en, m_im;
  logic [1:0]  m_mode;
  logic [31:0] m_preset, m_count;
  bit          m_flag;
  int          m_stage;

  task automatic model_reset();
    m_en = 0; m_im = 0; m_mode = 2'b00; m_preset = 0; m_count = 0; m_flag = 0; m_stage = M_IDLE;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a[31:4] != BASE[31:4]) return 32'd0;
    case (a[3:2])
      2'd0:    return {28'd0, m_im, m_mode, m_en};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    bit          is_wr, expired, reloading;
    bit          n_en, n_im, n_flag;
    logic [1:0]  n_mode;
    logic [31:0] n_preset, n_count;
    int          n_stage;
    is_wr    = (a[31:4] == BASE[31:4]) && (be != 4'd0);
    n_en = m_en; n_im = m_im; n_mode = m_mode; n_flag = m_flag;
    n_preset = m_preset; n_count = m_count; n_stage = m_stage;
    expired = 0; reloading = 0;
    case (m_stage)
      M_IDLE: if (m_en) n_stage = M_LOAD;
      M_LOAD: begin n_count = m_preset; n_stage = M_CNT; end
      M_CNT: begin
        if (!m_en) n_stage = M_IDLE;
        else if (m_count > 1) n_count = m_count - 1;
        else begin n_count = 0; expired = 1; n_stage = M_INT; end
      end
      default: begin
        if (m_mode == 2'b01) begin reloading = 1; n_stage = M_LOAD; end
        else begin n_en = 0; n_stage = M_IDLE; end
      end
    endcase
    if (is_wr && a[3:2] <= 2'd1) n_flag = 0;
    if (expired) n_flag = 1;
    if (reloading) n_flag = 0;
    if (is_wr && a[3:2] == 2'd0 && be[0]) begin
      n_en = d[0]; n_mode = d[2:1]; n_im = d[3];
    end
    if (is_wr && a[3:2] == 2'd1)
      for (int b = 0; b < 4; b++) if (be[b]) n_preset[8*b +: 8] = d[8*b +: 8];
    m_en = n_en; m_im = n_im; m_mode = n_mode; m_flag = n_flag;
    m_preset = n_preset; m_count = n_count; m_stage = n_stage;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[17];
  logic [31:0] exp_q[$];

  initial begin
    logic [31:0] v;
    logic [31:0] a, d, exp;
    logic [3:0]  be;
    int r;

    vecs[0]  = '{A_CTRL,   4'h0, 32'h0,         32'h0,         1'b0};
    vecs[1]  = '{A_PRESET, 4'h0, 32'h0,         32'h0,         1'b0};
    vecs[2]  = '{A_COUNT,  4'h0, 32'h0,         32'h0,         1'b0};
    vecs[3]  = '{A_RSVD,   4'h0, 32'h0,         32'h0,         1'b0};
    vecs[4]  = '{A_PRESET, 4'h1, 32'h1234_56ff, 32'h0,         1'b0};
    vecs[5]  = '{A_PRESET, 4'h0, 32'h0,         32'h0000_00ff, 1'b0};
    vecs[6]  = '{A_PRESET, 4'hc, 32'haabb_ccdd, 32'h0000_00ff, 1'b0};
    vecs[7]  = '{A_PRESET, 4'h0, 32'h0,         32'haabb_00ff, 1'b0};
    vecs[8]  = '{A_COUNT,  4'hf, 32'h0000_0055, 32'h0,         1'b0};
    vecs[9]  = '{A_COUNT,  4'h0, 32'h0,         32'h0,         1'b0};
    vecs[10] = '{A_RSVD,   4'hf, 32'h0000_0001, 32'h0,         1'b0};
    vecs[11] = '{A_RSVD,   4'h0, 32'h0,         32'h0,         1'b0};
    vecs[12] = '{A_CTRL,   4'hf, 32'hffff_fff6, 32'h0,         1'b0};
    vecs[13] = '{A_CTRL,   4'h0, 32'h0,         32'h0000_0006, 1'b0};
    vecs[14] = '{A_OTHER+4,4'hf, 32'h0000_0007, 32'h0,         1'b0};
    vecs[15] = '{A_PRESET, 4'h0, 32'h0,         32'haabb_00ff, 1'b0};
    vecs[16] = '{A_OTHER,  4'h0, 32'h0,         32'h0,         1'b0};

    // ---- table: reset state, byte lanes, read-only / reserved / unselected ----
    do_reset();
    for (int i = 0; i < 17; i++) begin
      addr = vecs[i].a; byteen = vecs[i].be; wdata = vecs[i].d;
      #1;
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rd);
      check($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, vecs[i].exp_irq});
      tick();
    end
    byteen = 4'd0;

    // ---- one-shot, PRESET=5, IM=1 ----
    do_reset();
    bus_write(A_PRESET, 4'hf, 32'd5);
    bus_write(A_CTRL, 4'hf, 32'h9);
    tick(); tick();
    rd(A_COUNT, v); check("os_count5", v, 32'd5);
    for (int k = 4; k >= 1; k--) begin
      tick(); rd(A_COUNT, v); check($sformatf("os_count%0d", k), v, k);
    end
    check("os_irq_before", {31'd0, irq}, 32'd0);
    tick();
    check("os_irq_set", {31'd0, irq}, 32'd1);
    rd(A_COUNT, v); check("os_count0", v, 32'd0);
    tick();
    rd(A_CTRL, v); check("os_en_cleared", v, 32'h8);
    repeat (3) tick();
    check("os_irq_held", {31'd0, irq}, 32'd1);
    bus_write(A_CTRL, 4'hf, 32'h0);
    check("os_irq_ack", {31'd0, irq}, 32'd0);

    // ---- auto-reload, PRESET=3: pulse every 5 cycles ----
    do_reset();
    bus_write(A_PRESET, 4'hf, 32'd3);
    bus_write(A_CTRL, 4'hf, 32'hb);
    for (int k = 1; k <= 20; k++) begin
      tick();
      check($sformatf("ar_irq_t%0d", k), {31'd0, irq}, {31'd0, (k % 5) == 0});
    end
    rd(A_CTRL, v); check("ar_en_kept", v, 32'hb);

    // ---- disable mid-count holds COUNT, re-enable reloads ----
    do_reset();
    bus_write(A_PRESET, 4'hf, 32'd10);
    bus_write(A_CTRL, 4'hf, 32'h9);
    tick(); tick();
    rd(A_COUNT, v); check("dis_count10", v, 32'd10);
    repeat (3) tick();
    rd(A_COUNT, v); check("dis_count7", v, 32'd7);
    bus_write(A_CTRL, 4'hf, 32'h8);
    tick();
    rd(A_COUNT, v); check("dis_count_hold", v, 32'd6);
    check("dis_state_idle", {30'd0, state_o}, 32'd0);
    repeat (4) tick();
    rd(A_COUNT, v); check("dis_count_still", v, 32'd6);
    check("dis_no_irq", {31'd0, irq}, 32'd0);
    bus_write(A_CTRL, 4'hf, 32'h9);
    tick(); tick();
    rd(A_COUNT, v); check("dis_reload10", v, 32'd10);

    // ---- IM=0 expiry, then set IM via CTRL write ----
    do_reset();
    bus_write(A_PRESET, 4'hf, 32'd2);
    bus_write(A_CTRL, 4'hf, 32'h1);
    repeat (6) tick();
    check("im0_irq", {31'd0, irq}, 32'd0);
    rd(A_CTRL, v); check("im0_en_cleared", v, 32'h0);
    bus_write(A_CTRL, 4'hf, 32'h8);
    check("im1_irq_after_write", {31'd0, irq}, 32'd0);
    tick();
    check("im1_irq_later", {31'd0, irq}, 32'd0);

    // ---- asynchronous reset mid-count ----
    do_reset();
    bus_write(A_PRESET, 4'hf, 32'd10);
    bus_write(A_CTRL, 4'hf, 32'h9);
    repeat (8) tick();
    rd(A_COUNT, v); check("rst_count4", v, 32'd4);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_state", {30'd0, state_o}, 32'd0);
    rd(A_CTRL, v);   check("rst_ctrl", v, 32'd0);
    rd(A_PRESET, v); check("rst_preset", v, 32'd0);
    rd(A_COUNT, v);  check("rst_count", v, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    bus_write(A_PRESET, 4'h1, 32'h0000_00ff);
    rd(A_PRESET, v); check("rst_preset_byte", v, 32'h0000_00ff);

    // ---- randomized traffic against the reference model ----
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      r = $urandom_range(0, 99);
      be = 4'd0; d = $urandom;
      if (r < 8) begin
        a = A_CTRL; be = 4'($urandom_range(1, 15));
      end else if (r < 14) begin
        a = A_PRESET; be = 4'hf; d = $urandom_range(0, 9);
      end else if (r < 17) begin
        a = BASE + {28'd0, 2'($urandom_range(2, 3)), 2'b00}; be = 4'($urandom_range(1, 15));
      end else if (r < 20) begin
        a = A_OTHER + {28'd0, 2'($urandom_range(0, 1)), 2'b00}; be = 4'hf;
      end else if (r < 24) begin
        a = A_OTHER + {28'd0, 2'($urandom_range(0, 3)), 2'b00};
      end else begin
        a = BASE + {28'd0, 2'($urandom_range(0, 3)), 2'b00};
      end
      addr = a; byteen = be; wdata = d;
      exp_q.push_back(model_read(a));
      #1;
      exp = exp_q.pop_front();
      check($sformatf("rnd%0d_rdata@%08h", cyc, a), rdata, exp);
      check($sformatf("rnd%0d_irq", cyc), {31'd0, irq}, {31'd0, m_flag & m_im});
      @(posedge clk);
      model_step(a, be, d);
      #1;
    end
    byteen = 4'd0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
